// File: rtl/ram_sized_hs.sv
// ram_sized_hs
//   Byte-addressed synchronous data RAM (2**ADDR_W x 8) with big-endian
//   byte/halfword/word access and a four-phase enable/mv handshake.
//   Each request is latched in IDLE, delayed WAIT cycles in BUSY, then
//   committed; DONE holds the result until enable is dropped.
// Ports
//   clk      : clock, all state changes on the rising edge
//   reset    : synchronous active-high reset (array contents kept)
//   enable   : request strobe, held until mv is seen
//   rw       : 1 = read, 0 = write
//   size     : 00 byte, 01 halfword, 10 word, 11 reserved
//   address  : byte address of the most significant byte accessed
//   DataIn   : right-aligned write data
//   DataOut  : right-aligned, zero-extended read data (0 for writes/errors)
//   mv       : access complete
//   err      : request rejected (misaligned or reserved size), qualified by mv
module ram_sized_hs #(
   parameter int ADDR_W = 8,
   parameter int WAIT   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              rw,
   input  logic [1:0]        size,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       DataIn,
   output logic [31:0]       DataOut,
   output logic              mv,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic              rw_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       din_q;

   logic [7:0]        mem [2**ADDR_W];

   logic [ADDR_W-1:0] a1, a2, a3;
   logic              legal;
   logic              commit;
   logic [31:0]       rd_data;

   always_comb begin
      a1 = addr_q + ADDR_W'(1);
      a2 = addr_q + ADDR_W'(2);
      a3 = addr_q + ADDR_W'(3);

      // Alignment guarantees multi-byte accesses never run past the top cell.
      case (size_q)
         2'b00:   legal = 1'b1;
         2'b01:   legal = ~addr_q[0];
         2'b10:   legal = (addr_q[1:0] == 2'b00);
         default: legal = 1'b0;
      endcase

      case (size_q)
         2'b00:   rd_data = {24'h0, mem[addr_q]};
         2'b01:   rd_data = {16'h0, mem[addr_q], mem[a1]};
         2'b10:   rd_data = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
         default: rd_data = '0;
      endcase

      commit = (state == BUSY) && (cnt == '0);
   end

   // Array write port; reset suppresses the commit so an aborted write never lands.
   always_ff @(posedge clk) begin
      if (!reset && commit && legal && !rw_q) begin
         case (size_q)
            2'b00: mem[addr_q] <= din_q[7:0];
            2'b01: begin
               mem[addr_q] <= din_q[15:8];
               mem[a1]     <= din_q[7:0];
            end
            2'b10: begin
               mem[addr_q] <= din_q[31:24];
               mem[a1]     <= din_q[23:16];
               mem[a2]     <= din_q[15:8];
               mem[a3]     <= din_q[7:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         mv      <= 1'b0;
         err     <= 1'b0;
         DataOut <= '0;
         rw_q    <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         din_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  rw_q   <= rw;
                  size_q <= size;
                  addr_q <= address;
                  din_q  <= DataIn;
                  cnt    <= 4'(WAIT);
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  mv      <= 1'b1;
                  err     <= ~legal;
                  DataOut <= (legal && rw_q) ? rd_data : '0;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (!enable) begin
                  mv      <= 1'b0;
                  err     <= 1'b0;
                  DataOut <= '0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
